sram_seq_ctrl: RTL and testbench
================================

SRAM_SEQ_CTRL -- requirements
Module: sram_seq_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 100_000_000: number of clk cycles each scanned word is held on the display.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for button inputs.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 btn_wr  in  1  raw write button; each rising edge stores sw_data.
REQ-006 btn_scan  in  1  raw scan button; each rising edge starts a readback of all 8 words.
REQ-007 sw_data  in  8  switch data to be written.
REQ-008 mem_dout  in  8  data returned by the 8x8 memory.
REQ-009 mem_addr  out  3  memory address.
REQ-010 mem_din  out  8  memory write data.
REQ-011 mem_we  out  1  memory write enable, one-cycle pulse.
REQ-012 mem_isyi  out  1  memory read-mode select; tied 0 (synchronous read path).
REQ-013 disp_addr  out  3  address of the displayed word.
REQ-014 disp_data  out  8  displayed word.
REQ-015 disp_valid  out  1  one-cycle pulse when disp_addr/disp_data update.
REQ-016 busy  out  1  high while a scan is in progress.

Function
REQ-017 Each button shall pass through a SYNC_STAGES-flop synchroniser plus edge register; a 0->1 input yields exactly one 1-cycle internal pulse, SYNC_STAGES+1 cycles later.
REQ-018 FSM states: IDLE, WRITE, RD_ADDR, RD_CAP, HOLD.
REQ-019 IDLE: wr pulse -> WRITE; else scan pulse -> RD_ADDR with scan_ptr=0; else stay.
REQ-020 Simultaneous wr and scan pulses in IDLE: write wins, scan pulse discarded.
REQ-021 WRITE (1 cycle): mem_we=1, mem_addr=wr_ptr, mem_din=sw_data; then wr_ptr+1 modulo 8 (7 wraps to 0), -> IDLE.
REQ-022 RD_ADDR (1 cycle): mem_we=0, mem_addr=scan_ptr -> RD_CAP.
REQ-023 RD_CAP (1 cycle): mem_dout is valid; on its closing edge disp_data<=mem_dout, disp_addr<=scan_ptr, disp_valid=1 for the following cycle; -> HOLD.
REQ-024 HOLD: count exactly TICK_CYCLES cycles; then scan_ptr==7 -> IDLE, else scan_ptr+1 -> RD_ADDR.
REQ-025 busy=1 in RD_ADDR, RD_CAP, HOLD; 0 otherwise.
REQ-026 Button pulses arriving while busy or in WRITE shall be discarded, not queued.
REQ-027 mem_we shall be 0 in every state except WRITE; mem_isyi constant 0.
REQ-028 Outside WRITE, RD_ADDR and RD_CAP, mem_addr shall hold its last value and mem_din shall be 0.
REQ-029 wr_ptr is unaffected by a scan; scan_ptr is unaffected by writes.
REQ-030 Hold counter width = clog2(TICK_CYCLES)+1; TICK_CYCLES=1 yields a 1-cycle HOLD.

Reset
REQ-031 rst_n low shall immediately force: state IDLE, wr_ptr=0, scan_ptr=0, hold counter 0, synchroniser/edge flops 0, mem_addr=0, mem_din=0, mem_we=0, disp_addr=0, disp_data=0, disp_valid=0, busy=0.
REQ-032 Reset mid-scan or mid-WRITE aborts the operation with no further mem_we pulse; memory contents are not cleared (memory has no reset).
REQ-033 A button held high through reset release shall not produce a pulse until it goes low and high again.

Structure
REQ-034 Shared package holds ADDR_W=3, DATA_W=8, DEPTH=8 and the FSM state enumeration.
REQ-035 One sub-module, btn_edge (synchroniser plus rising-edge pulse), instantiated twice.

Verification (TICK_CYCLES=4, behavioural 8x8 memory model attached)
REQ-036 Reset then press btn_wr 8 times with sw_data=8'h10..8'h17 -> eight single-cycle mem_we pulses, addresses 0..7 in order, mem_din matching.
REQ-037 Ninth btn_wr with sw_data=8'hAA -> mem_we at address 0 (wrap), word 0 becomes 8'hAA.
REQ-038 btn_scan -> disp_valid 8 times at 6-cycle spacing (RD_ADDR, RD_CAP, 4 HOLD), disp_addr 0..7, disp_data AA,11..17; busy falls in the cycle after the last HOLD.
REQ-039 btn_wr and btn_scan rising in the same cycle -> one write, no scan; btn_wr pressed during scan -> no mem_we, scan completes unchanged.
REQ-040 rst_n low during HOLD of address 3 -> all outputs 0 asynchronously, busy=0; after release a new scan restarts at address 0 and memory still reads AA,11..17.

Source files
------------

// File: rtl/sram_seq_ctrl_pkg.sv
// Shared sizes and FSM state codes for the SRAM write/scan sequencer.
package sram_seq_ctrl_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WRITE   = 3'd1;
  localparam state_t ST_RD_ADDR = 3'd2;
  localparam state_t ST_RD_CAP  = 3'd3;
  localparam state_t ST_HOLD    = 3'd4;
endpackage

// File: rtl/sram_seq_ctrl_btn_edge.sv
// Button synchroniser plus registered rising-edge pulse generator.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   r_pulse;
  logic                   w_s;
  logic                   w_ready;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_ready = r_fill[SYNC_STAGES-1];
  assign o_pulse = r_pulse;

  // r_armed stays low until a settled low level is seen, so a button held
  // through reset release cannot fire until it is released and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync[0] <= i_btn;
      r_fill[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_fill[i] <= r_fill[i-1];
      end
      r_prev  <= w_s;
      r_armed <= r_armed | (w_ready & ~w_s);
      r_pulse <= r_armed & w_s & ~r_prev;
    end
  end
endmodule

// File: rtl/sram_seq_ctrl.sv
// Button-driven sequencer: writes switch data to an 8x8 SRAM, scans it back to a display.
module sram_seq_ctrl
  import sram_seq_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_wr,
  input  logic              btn_scan,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_isyi,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);
  localparam int CNT_W = $clog2(TICK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic              w_wr_pulse;
  logic              w_scan_pulse;
  logic [ADDR_W-1:0] w_mem_addr;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_scan_ptr;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_edge (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_wr), .o_pulse(w_wr_pulse)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scan_edge (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_scan), .o_pulse(w_scan_pulse)
  );

  // Strobes are decoded from state so a reset drops them immediately.
  always_comb begin
    w_mem_addr = r_addr_q;
    case (r_state)
      ST_WRITE:             w_mem_addr = r_wr_ptr;
      ST_RD_ADDR, ST_RD_CAP: w_mem_addr = r_scan_ptr;
      default:              w_mem_addr = r_addr_q;
    endcase
  end

  assign mem_addr   = w_mem_addr;
  assign mem_we     = (r_state == ST_WRITE);
  assign mem_din    = mem_we ? sw_data : '0;
  assign mem_isyi   = 1'b0;
  assign busy       = (r_state == ST_RD_ADDR) || (r_state == ST_RD_CAP) ||
                      (r_state == ST_HOLD);
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_scan_ptr   <= '0;
      r_hold_cnt   <= '0;
      r_addr_q     <= '0;
      r_disp_addr  <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_addr_q     <= w_mem_addr;
      r_disp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_pulse) begin
            r_state <= ST_WRITE;
          end else if (w_scan_pulse) begin
            r_scan_ptr <= '0;
            r_state    <= ST_RD_ADDR;
          end
        end
        ST_WRITE: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_RD_ADDR: r_state <= ST_RD_CAP;
        ST_RD_CAP: begin
          r_disp_data  <= mem_dout;
          r_disp_addr  <= r_scan_ptr;
          r_disp_valid <= 1'b1;
          r_hold_cnt   <= '0;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold_cnt == CNT_LAST) begin
            r_hold_cnt <= '0;
            if (r_scan_ptr == ADDR_W'(DEPTH - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_scan_ptr <= r_scan_ptr + 1'b1;
              r_state    <= ST_RD_ADDR;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Randomised self-checking bench for sram_seq_ctrl with a behavioural 8x8 SRAM.
module tb_sram_seq_ctrl;
  localparam int TICK = 4;
  localparam int SCAN_SPACING = 2 + TICK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_wr = 1'b0;
  logic       btn_scan = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic [7:0] mem_dout;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic       mem_isyi;
  logic [2:0] disp_addr;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       busy;

  sram_seq_ctrl #(.TICK_CYCLES(TICK), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_wr(btn_wr), .btn_scan(btn_scan),
    .sw_data(sw_data), .mem_dout(mem_dout), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_isyi(mem_isyi),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // attached memory: synchronous write and synchronous read, no reset
  logic [7:0] sram [8];
  initial for (int i = 0; i < 8; i++) sram[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  // reference model: what memory should hold and where the next write goes
  logic [7:0] exp_mem [8];
  int         exp_wp;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // event monitor
  int         cyc = 0;
  logic [10:0] we_q[$];
  logic [10:0] disp_q[$];
  int         disp_t[$];
  int         busy_cycles = 0;
  int         busy_fall_cyc = -1;
  logic       busy_prev = 1'b0;
  int         bad_din = 0;
  int         bad_isyi = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) we_q.push_back({mem_addr, mem_din});
    if (disp_valid) begin
      disp_q.push_back({disp_addr, disp_data});
      disp_t.push_back(cyc);
    end
    if (busy) busy_cycles <= busy_cycles + 1;
    if (busy_prev && !busy && rst_n) busy_fall_cyc <= cyc;
    busy_prev <= busy;
    if (!mem_we && mem_din != 8'h00) bad_din <= bad_din + 1;
    if (mem_isyi !== 1'b0) bad_isyi <= bad_isyi + 1;
  end

  task automatic clear_log();
    we_q.delete();
    disp_q.delete();
    disp_t.delete();
    busy_cycles = 0;
    busy_fall_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_wr(input logic [7:0] d, input string tag);
    clear_log();
    sw_data = d;
    btn_wr = 1'b1;
    idle(6);
    btn_wr = 1'b0;
    idle(8);
    chk({tag, ".we_count"}, we_q.size(), 1);
    if (we_q.size() >= 1) begin
      chk({tag, ".addr"}, {21'd0, we_q[0][10:8]}, exp_wp);
      chk({tag, ".din"}, {24'd0, we_q[0][7:0]}, {24'd0, d});
    end
    chk({tag, ".sram"}, {24'd0, sram[exp_wp]}, {24'd0, d});
    exp_mem[exp_wp] = d;
    exp_wp = (exp_wp + 1) % 8;
  endtask

  task automatic wait_busy_fall(input int bound, input string tag);
    int n = 0;
    while (busy_fall_cyc < 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".timeout"}, (busy_fall_cyc < 0), 0);
  endtask

  task automatic do_scan(input bit inject_wr, input string tag);
    int n;
    clear_log();
    btn_scan = 1'b1;
    idle(6);
    btn_scan = 1'b0;
    if (inject_wr) begin
      idle(6);
      sw_data = 8'($urandom);
      btn_wr = 1'b1;
      idle(6);
      btn_wr = 1'b0;
    end
    wait_busy_fall(200, tag);
    n = disp_q.size();
    chk({tag, ".disp_count"}, n, 8);
    for (int i = 0; i < n && i < 8; i++) begin
      chk({tag, ".disp_addr"}, {21'd0, disp_q[i][10:8]}, i);
      chk({tag, ".disp_data"}, {24'd0, disp_q[i][7:0]}, {24'd0, exp_mem[i]});
      if (i > 0) chk({tag, ".spacing"}, disp_t[i] - disp_t[i-1], SCAN_SPACING);
    end
    if (n > 0) chk({tag, ".busy_fall"}, busy_fall_cyc - disp_t[n-1], TICK);
    chk({tag, ".busy_cycles"}, busy_cycles, 8 * SCAN_SPACING);
    chk({tag, ".no_we"}, we_q.size(), 0);
    idle(6);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {8'd0, mem_addr, mem_din, mem_we, disp_addr, disp_data, disp_valid},
        32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
    exp_wp = 0;

    // reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk_all_zero("post_reset");

    // fill memory, then wrap
    for (int i = 0; i < 8; i++) press_wr(8'h10 + 8'(i), "fill");
    press_wr(8'hAA, "wrap");

    do_scan(1'b0, "scan1");
    do_scan(1'b1, "scan_wr_ignored");

    // reset during HOLD of address 3
    clear_log();
    btn_scan = 1'b1;
    idle(6);
    btn_scan = 1'b0;
    n = 0;
    while (disp_q.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid.reach_addr3", disp_q.size(), 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    clear_log();
    idle(2);
    chk("rst_mid.no_we", we_q.size(), 0);
    rst_n = 1'b1;
    exp_wp = 0;
    idle(5);
    do_scan(1'b0, "scan_after_rst");

    // simultaneous presses: write wins, no scan
    clear_log();
    sw_data = 8'h5C;
    btn_wr = 1'b1;
    btn_scan = 1'b1;
    idle(6);
    btn_wr = 1'b0;
    btn_scan = 1'b0;
    idle(40);
    chk("simul.we_count", we_q.size(), 1);
    if (we_q.size() >= 1) chk("simul.addr", {21'd0, we_q[0][10:8]}, exp_wp);
    chk("simul.no_disp", disp_q.size(), 0);
    chk("simul.no_busy", busy_cycles, 0);
    exp_mem[exp_wp] = 8'h5C;
    exp_wp = (exp_wp + 1) % 8;

    // button held through reset release must not fire
    @(negedge clk);
    rst_n = 1'b0;
    btn_wr = 1'b1;
    sw_data = 8'h77;
    idle(2);
    rst_n = 1'b1;
    exp_wp = 0;
    clear_log();
    idle(15);
    chk("held_rst.no_we", we_q.size(), 0);
    btn_wr = 1'b0;
    idle(8);
    press_wr(8'h3E, "held_rst.repress");

    // randomized mix of writes and scans
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) do_scan($urandom_range(0, 1) == 1, "rnd_scan");
      else press_wr(8'($urandom), "rnd_wr");
      idle($urandom_range(0, 5));
    end
    do_scan(1'b0, "final_scan");

    chk("din_zero_when_idle", bad_din, 0);
    chk("isyi_zero", bad_isyi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
